// File: rtl/bin_to_bcd_display.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_display
//
// Converts a 32-bit unsigned operand into eight packed BCD digits using the
// shift-and-add-3 (double dabble) algorithm, one bit per clock. It also
// produces a per-digit enable mask for a multiplexed 7-segment display, with
// optional leading-zero suppression.
//
// The conversion takes a fixed 33 edges after the start edge:
//   - 32 SHIFT edges.
//   - 1 LOAD edge that registers the results.
//
// Operands above 99,999,999 do not fit in eight digits. For these, the
// display shows OVF_PATTERN with all digits lit.
//
// Ports
//   clock        system clock, rising-edge active
//   reset        synchronous active-high reset
//   start        conversion request, accepted only while idle
//   binary       unsigned operand, captured with start
//   blank_zeros  leading-zero suppression select, captured with start
//   point_in     per-digit decimal-point request, captured with start
//   value        eight packed BCD digits, digit 0 in bits [3:0]
//   enable       per-digit enable mask
//   point        registered decimal-point mask of the last completion
//   busy         high while a conversion is in flight
//   done         one-cycle pulse when new results appear
//   overflow     last completed operand exceeded 99,999,999
// -----------------------------------------------------------------------------
module bin_to_bcd_display #(
    parameter logic [31:0] OVF_PATTERN = 32'hEEEEEEEE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] binary,
    input  logic        blank_zeros,
    input  logic [7:0]  point_in,
    output logic [31:0] value,
    output logic [7:0]  enable,
    output logic [7:0]  point,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    localparam logic [31:0] MAX_DISPLAY = 32'd99_999_999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [31:0] operand_reg;
    logic [31:0] acc_reg;
    logic [4:0]  count_reg;
    logic        blank_reg;
    logic [7:0]  pt_latch_reg;
    logic        ovf_latch_reg;

    logic [31:0] value_reg;
    logic [7:0]  enable_reg;
    logic [7:0]  point_reg;
    logic        overflow_reg;
    logic        done_reg;

    logic [31:0] acc_adj;
    logic [31:0] acc_shift;
    logic [7:0]  digit_live;
    logic [7:0]  digit_keep;
    logic [31:0] load_value;
    logic [7:0]  load_enable;

    // Add 3 to every nibble that is 5 or more, so that the following left
    // shift carries correctly into the next decimal digit.
    for (genvar gi = 0; gi < 8; gi++) begin : g_adjust
        assign acc_adj[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5) ?
                                    acc_reg[4*gi +: 4] + 4'd3 :
                                    acc_reg[4*gi +: 4];
    end

    assign acc_shift = {acc_adj[30:0], operand_reg[31]};

    // A digit stays lit if it holds a nonzero digit or a point request, or if
    // any more significant digit does. The keep signal is computed as a
    // running OR from the top digit downwards.
    for (genvar gi = 0; gi < 8; gi++) begin : g_blank
        assign digit_live[gi] = (acc_reg[4*gi +: 4] != 4'd0) | pt_latch_reg[gi];

        if (gi == 7) begin : g_top
            assign digit_keep[gi] = digit_live[gi];
        end else begin : g_lower
            assign digit_keep[gi] = digit_live[gi] | digit_keep[gi+1];
        end
    end

    always_comb begin
        load_value  = acc_reg;
        load_enable = 8'hFF;

        if (ovf_latch_reg) begin
            load_value  = OVF_PATTERN;
            load_enable = 8'hFF;
        end else if (blank_reg) begin
            // Digit 0 is always lit, so a zero result still shows "0".
            load_enable = {digit_keep[7:1], 1'b1};
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;

        case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (count_reg == 5'd31) state_next = LOAD;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy = (state_reg != IDLE);
    end

    // Datapath and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            operand_reg   <= 32'h0;
            acc_reg       <= 32'h0;
            count_reg     <= 5'd0;
            blank_reg     <= 1'b0;
            pt_latch_reg  <= 8'h00;
            ovf_latch_reg <= 1'b0;
            value_reg     <= 32'h0;
            enable_reg    <= 8'h01;
            point_reg     <= 8'h00;
            overflow_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        operand_reg   <= binary;
                        blank_reg     <= blank_zeros;
                        pt_latch_reg  <= point_in;
                        // The operand is shifted away during conversion, so
                        // the range test is taken from the unshifted value.
                        ovf_latch_reg <= (binary > MAX_DISPLAY);
                        acc_reg       <= 32'h0;
                        count_reg     <= 5'd0;
                    end
                end

                SHIFT: begin
                    acc_reg     <= acc_shift;
                    operand_reg <= operand_reg << 1;
                    count_reg   <= count_reg + 5'd1;
                end

                LOAD: begin
                    value_reg    <= load_value;
                    enable_reg   <= load_enable;
                    point_reg    <= pt_latch_reg;
                    overflow_reg <= ovf_latch_reg;
                    done_reg     <= 1'b1;
                end

                default: ;
            endcase
        end
    end

    assign value    = value_reg;
    assign enable   = enable_reg;
    assign point    = point_reg;
    assign overflow = overflow_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_display
//
// Self-checking bench for bin_to_bcd_display.
//
// Stimulus:
//   - Directed cases.
//   - Randomized conversions.
//
// Reference model:
//   - Expected digits come from decimal division.
//   - The enable mask lights every digit up to the most significant digit
//     that is nonzero or has its point set.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_display;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] binary;
    logic        blank_zeros;
    logic [7:0]  point_in;
    logic [31:0] value;
    logic [7:0]  enable;
    logic [7:0]  point;
    logic        busy;
    logic        done;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    string case_name = "init";

    // Results of the last completed conversion (what the outputs must hold).
    logic [31:0] prev_value;
    logic [7:0]  prev_enable;
    logic [7:0]  prev_point;
    logic        prev_ovf;

    bin_to_bcd_display #(
        .OVF_PATTERN(32'hEEEEEEEE)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .binary     (binary),
        .blank_zeros(blank_zeros),
        .point_in   (point_in),
        .value      (value),
        .enable     (enable),
        .point      (point),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s [%s]: got %h, expected %h", tag, case_name, obs, exp);
        end
    endtask

    function automatic void model(input logic [31:0] bin, input logic blank,
                                  input logic [7:0] pt, output logic [31:0] val,
                                  output logic [7:0] en, output logic ovf);
        logic [31:0] rem;
        logic [31:0] digit;
        int top;

        ovf = (bin > 32'd99_999_999);
        if (ovf) begin
            val = 32'hEEEEEEEE;
            en  = 8'hFF;
            return;
        end

        rem = bin;
        val = 32'h0;
        top = 0;
        for (int i = 0; i < 8; i++) begin
            digit          = rem % 10;
            val[4*i +: 4]  = digit[3:0];
            rem            = rem / 10;
            if (digit != 0 || pt[i]) top = i;
        end
        en = blank ? 8'((2 << top) - 1) : 8'hFF;
    endfunction

    task automatic check_reset_outputs();
        check_eq("rst_value",    value,    32'h0);
        check_eq("rst_enable",   {24'h0, enable},   32'h01);
        check_eq("rst_point",    {24'h0, point},    32'h00);
        check_eq("rst_busy",     {31'h0, busy},     32'h0);
        check_eq("rst_done",     {31'h0, done},     32'h0);
        check_eq("rst_overflow", {31'h0, overflow}, 32'h0);
        prev_value  = 32'h0;
        prev_enable = 8'h01;
        prev_point  = 8'h00;
        prev_ovf    = 1'b0;
    endtask

    // One conversion.
    //   inject_at > 0 : pulse a conflicting start sampled on that edge.
    //   reset_at  > 0 : assert reset sampled on that edge (aborts the run).
    task automatic run_conv(input logic [31:0] bin, input logic blank,
                            input logic [7:0] pt, input int inject_at,
                            input int reset_at);
        logic [31:0] ev;
        logic [7:0]  ee;
        logic        eo;

        model(bin, blank, pt, ev, ee, eo);
        binary      = bin;
        blank_zeros = blank;
        point_in    = pt;
        start       = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check_eq("busy_e0", {31'h0, busy}, 32'h1);

        for (int e = 1; e <= 33; e++) begin
            if (e == inject_at) begin
                start       = 1'b1;
                binary      = ~bin;
                blank_zeros = ~blank;
                point_in    = ~pt;
            end
            if (e == reset_at) reset = 1'b1;

            @(posedge clock); #1;
            start       = 1'b0;
            binary      = bin;
            blank_zeros = blank;
            point_in    = pt;

            if (e == reset_at) begin
                reset = 1'b0;
                check_reset_outputs();
                for (int k = 0; k < 40; k++) begin
                    @(posedge clock); #1;
                    check_eq("abort_done", {31'h0, done}, 32'h0);
                end
                $display("conv %s bin=%h aborted by reset at E%0d", case_name, bin, e);
                return;
            end

            if (e < 33) begin
                check_eq("mid_done",     {31'h0, done},     32'h0);
                check_eq("mid_busy",     {31'h0, busy},     32'h1);
                check_eq("hold_value",   value,             prev_value);
                check_eq("hold_enable",  {24'h0, enable},   {24'h0, prev_enable});
                check_eq("hold_point",   {24'h0, point},    {24'h0, prev_point});
                check_eq("hold_ovf",     {31'h0, overflow}, {31'h0, prev_ovf});
            end else begin
                check_eq("done_e33",     {31'h0, done},     32'h1);
                check_eq("busy_e33",     {31'h0, busy},     32'h0);
                check_eq("value",        value,             ev);
                check_eq("enable",       {24'h0, enable},   {24'h0, ee});
                check_eq("point",        {24'h0, point},    {24'h0, pt});
                check_eq("overflow",     {31'h0, overflow}, {31'h0, eo});
            end
        end

        prev_value  = ev;
        prev_enable = ee;
        prev_point  = pt;
        prev_ovf    = eo;

        @(posedge clock); #1;
        check_eq("done_pulse_end", {31'h0, done}, 32'h0);
        $display("conv %s bin=%h blank=%b pt=%h -> value=%h enable=%h ovf=%b",
                 case_name, bin, blank, pt, value, enable, overflow);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ev1;
        logic [31:0] ev2;
        logic [7:0]  ee1;
        logic [7:0]  ee2;
        logic        eo1;
        logic        eo2;

        reset       = 1'b1;
        start       = 1'b0;
        binary      = 32'h0;
        blank_zeros = 1'b0;
        point_in    = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        case_name = "reset";
        check_reset_outputs();

        // Reset dominates start.
        case_name = "reset_vs_start";
        reset  = 1'b1;
        start  = 1'b1;
        binary = 32'd42;
        @(posedge clock); #1;
        reset = 1'b0;
        start = 1'b0;
        check_reset_outputs();
        @(posedge clock); #1;
        check_eq("no_busy", {31'h0, busy}, 32'h0);

        case_name = "12345678";  run_conv(32'd12345678, 1'b1, 8'h00, 0, 0);
        case_name = "12345_b1";  run_conv(32'd12345,    1'b1, 8'h00, 0, 0);
        case_name = "12345_b0";  run_conv(32'd12345,    1'b0, 8'h00, 0, 0);
        case_name = "zero_b1";   run_conv(32'd0,        1'b1, 8'h00, 0, 0);
        case_name = "five_pt";   run_conv(32'd5,        1'b1, 8'h04, 0, 0);
        case_name = "ovf_100M";  run_conv(32'd100_000_000, 1'b1, 8'h10, 0, 0);
        case_name = "ovf_max";   run_conv(32'hFFFFFFFF, 1'b1, 8'h00, 0, 0);
        case_name = "max_disp";  run_conv(32'd99_999_999, 1'b1, 8'h00, 0, 0);
        case_name = "ignore_e10"; run_conv(32'd87654321, 1'b1, 8'h02, 10, 0);
        case_name = "reset_e15"; run_conv(32'd4242,     1'b1, 8'h00, 0, 15);
        case_name = "after_rst"; run_conv(32'd4242,     1'b1, 8'h00, 0, 0);

        // start held high: second conversion accepted at E34.
        case_name = "back2back";
        a = 32'd31415926;
        b = 32'd2718;
        model(a, 1'b1, 8'h00, ev1, ee1, eo1);
        model(b, 1'b1, 8'h00, ev2, ee2, eo2);
        binary      = a;
        blank_zeros = 1'b1;
        point_in    = 8'h00;
        start       = 1'b1;
        @(posedge clock); #1;
        binary = b;
        for (int e = 1; e <= 33; e++) begin
            @(posedge clock); #1;
            check_eq("b2b_done1", {31'h0, done}, (e == 33) ? 32'h1 : 32'h0);
        end
        check_eq("b2b_value1",  value,           ev1);
        check_eq("b2b_enable1", {24'h0, enable}, {24'h0, ee1});
        @(posedge clock); #1;
        start = 1'b0;
        check_eq("b2b_accept", {31'h0, busy}, 32'h1);
        check_eq("b2b_done0",  {31'h0, done}, 32'h0);
        for (int e = 1; e <= 33; e++) begin
            @(posedge clock); #1;
            check_eq("b2b_done2", {31'h0, done}, (e == 33) ? 32'h1 : 32'h0);
        end
        check_eq("b2b_value2",  value,           ev2);
        check_eq("b2b_enable2", {24'h0, enable}, {24'h0, ee2});
        prev_value  = ev2;
        prev_enable = ee2;
        prev_point  = 8'h00;
        prev_ovf    = eo2;
        $display("conv back2back a=%h b=%h -> value=%h enable=%h", a, b, value, enable);
        @(posedge clock); #1;

        // Randomized conversions.
        for (int n = 0; n < 30; n++) begin
            logic [31:0] r;
            logic [7:0]  p;
            case ($urandom_range(0, 3))
                0:       r = $urandom;
                1:       r = $urandom_range(0, 99_999_999);
                2:       r = $urandom_range(0, 999);
                default: r = $urandom_range(99_999_990, 100_000_009);
            endcase
            p = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            case_name = $sformatf("rand%0d", n);
            run_conv(r, 1'($urandom_range(0, 1)), p, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_display.md
BIN_TO_BCD_DISPLAY -- requirements
Module: bin_to_bcd_display

Interface
REQ-001 Parameter: OVF_PATTERN, 32'hEEEEEEEE, the value driven on the value output when the latched operand exceeds 99,999,999.
REQ-002 Port: clock  input  1  single system clock; all state updates SHALL occur on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  conversion request, sampled on a rising edge only while idle.
REQ-005 Port: binary  input  32  unsigned operand, captured on the accepted start edge.
REQ-006 Port: blank_zeros  input  1  leading-zero suppression select, captured on the accepted start edge.
REQ-007 Port: point_in  input  8  per-digit decimal-point request, captured on the accepted start edge; bit i maps to digit i.
REQ-008 Port: value  output  32  eight packed BCD digits; digit i occupies bits [4i+3:4i], and digit 0 is least significant.
REQ-009 Port: enable  output  8  per-digit enable mask; bit i=1 lights digit i.
REQ-010 Port: point  output  8  registered copy of the latched point_in.
REQ-011 Port: busy  output  1  high whenever the state is not IDLE.
REQ-012 Port: done  output  1  one-cycle pulse, high in the cycle in which new value, enable, point and overflow first appear.
REQ-013 Port: overflow  output  1  high when the last completed operand exceeded 99,999,999; held until the next completion or reset.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and LOAD.
REQ-015 IDLE with start=1 at rising edge E0: latch binary, blank_zeros and point_in; clear the 32-bit BCD accumulator and the 5-bit bit counter; go to SHIFT.
REQ-016 SHIFT, each edge: add 3 to every accumulator nibble >= 5, then shift the accumulator left by 1, inserting the operand MSB; shift the operand left by 1; increment the counter.
REQ-017 Exactly 32 shift edges (E1..E32) SHALL occur; the edge on which the counter equals 31 SHALL move the FSM to LOAD.
REQ-018 LOAD (edge E33): register value, enable, point and overflow; set done=1; go to IDLE.
REQ-019 Latency SHALL be fixed: outputs update on the 33rd edge after the edge that accepted start; busy SHALL be 1 from after E0 until E33 and 0 after E33.
REQ-020 start while busy=1 SHALL be ignored, with no effect on the latched operands or the in-flight conversion.
REQ-021 start held continuously high SHALL produce one conversion every 34 cycles: the next start is accepted at E34.
REQ-022 done SHALL be 1 for exactly one cycle per completed conversion and 0 otherwise.
REQ-023 overflow = latched operand > 32'd99_999_999, computed on the latched binary value and independent of the BCD accumulator.
REQ-024 On overflow: value = OVF_PATTERN, enable = 8'hFF, point = latched point_in; blanking SHALL NOT apply.
REQ-025 No overflow, blank_zeros=0: value = accumulator and enable = 8'hFF.
REQ-026 No overflow, blank_zeros=1, enable[0] SHALL be 1 always.
REQ-027 No overflow, blank_zeros=1, for i>0, enable[i] SHALL be 1 if digit i is nonzero, or any digit j>i is nonzero, or point_in[j]=1 for any j>=i; otherwise enable[i] SHALL be 0.
REQ-028 value, enable, point and overflow SHALL remain stable between LOAD edges; a new conversion SHALL NOT disturb them until its own LOAD edge.

Reset
REQ-029 reset=1 at a rising edge SHALL force IDLE and clear the accumulator and counter.
REQ-030 reset=1 at a rising edge SHALL set value=32'h0, enable=8'h01, point=8'h00, busy=0, done=0 and overflow=0.
REQ-031 reset SHALL dominate start in the same cycle.
REQ-032 reset mid-conversion SHALL abort the conversion with no done pulse.
REQ-033 The first start accepted after reset deasserts SHALL behave exactly as REQ-015 to REQ-019.

Verification
REQ-034 binary=32'd12345678, blank_zeros=1, point_in=0 -> at E33: value=32'h12345678, enable=8'hFF, overflow=0, done pulse of exactly 1 cycle.
REQ-035 binary=32'd12345, blank_zeros=1 -> value=32'h00012345, enable=8'h1F; same operand with blank_zeros=0 -> enable=8'hFF.
REQ-036 binary=0, blank_zeros=1, point_in=0 -> value=0, enable=8'h01; binary=5, point_in=8'h04 -> value=32'h5, enable=8'h07, point=8'h04.
REQ-037 binary=32'd100_000_000 and binary=32'hFFFFFFFF -> overflow=1, value=32'hEEEEEEEE, enable=8'hFF; then binary=32'd99_999_999 -> overflow=0, value=32'h99999999.
REQ-038 Second start (different binary) pulsed at E10 of a conversion -> ignored; first result appears unchanged at E33, busy drops, no second done pulse.
REQ-039 reset asserted at E15 of a conversion -> all outputs equal their reset values and no done pulse occurs; a fresh start then completes 33 edges later with the correct value.
